// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared types and constants for the instruction buffer.
//   IbufEntry        : packed queue entry {inst, pc, fsq_offset}, 80 bits
//   IBUF_DEPTH       : queue entries (power of two)
//   IBUF_PTR_W       : head/tail pointer width
//   IBUF_FETCH_WIDTH : slots per fetch bundle
//   IBUF_DEC_WIDTH   : lanes handed to decode per cycle
//   popcount()       : number of set bits in a vector of up to 32 bits
package ibuf_pkg;

    localparam int VADDR_SIZE       = 39;
    localparam int FSQ_OFF_W        = 9;
    localparam int IBUF_DEPTH       = 16;
    localparam int IBUF_PTR_W       = $clog2(IBUF_DEPTH);
    localparam int IBUF_FETCH_WIDTH = 4;
    localparam int IBUF_DEC_WIDTH   = 4;

    typedef struct packed {
        logic [31:0]            inst;
        logic [VADDR_SIZE-1:0]  pc;
        logic [FSQ_OFF_W-1:0]   fsq_offset;
    } IbufEntry;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ibuf_compact.sv
// ibuf_compact: turns a (possibly sparse) fetch valid mask into per-slot
// write offsets so that valid slots land in consecutive queue entries.
//   mask   in   FETCH_WIDTH          per-slot valid, slot 0 oldest
//   offset out  FETCH_WIDTH*OFF_W    slot i offset = number of valid slots below i
//   enq_n  out  OFF_W                total valid slots in the bundle
// Purely combinational.
module ibuf_compact
    import ibuf_pkg::*;
#(
    parameter int FETCH_WIDTH = IBUF_FETCH_WIDTH,
    parameter int OFF_W       = $clog2(FETCH_WIDTH) + 1
) (
    input  logic [FETCH_WIDTH-1:0]       mask,
    output logic [FETCH_WIDTH*OFF_W-1:0] offset,
    output logic [OFF_W-1:0]             enq_n
);

    logic [OFF_W-1:0] run_sum;

    // Exclusive prefix sum: each slot's offset counts only older valid slots.
    always_comb begin
        run_sum = '0;
        offset  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            offset[i*OFF_W +: OFF_W] = run_sum;
            run_sum = run_sum + OFF_W'(mask[i]);
        end
        enq_n = OFF_W'(popcount(32'(mask)));
    end

endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and decode.
// Accepts one compacted fetch bundle per cycle and presents up to DEC_WIDTH
// oldest entries to decode; decode takes all valid lanes or none.
//   clk, rst   clock, synchronous active-high reset
//   flush      redirect; empties the queue next cycle, drops same-cycle enqueue
//   in_valid / in_ready / in_mask / in_data   fetch bundle handshake
//   stall      backend cannot accept this cycle
//   out_valid / out_data                      thermometer-masked decode lanes
//   count      registered occupancy
// Optional macro IBUF_PERF_EN adds perf_full / perf_empty saturating counters.
module inst_buffer
    import ibuf_pkg::*;
#(
    parameter int DEPTH       = IBUF_DEPTH,
    parameter int FETCH_WIDTH = IBUF_FETCH_WIDTH,
    parameter int DEC_WIDTH   = IBUF_DEC_WIDTH,
    parameter int ENTRY_W     = $bits(IbufEntry)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FETCH_WIDTH-1:0]         in_mask,
    input  logic [FETCH_WIDTH*ENTRY_W-1:0] in_data,
    input  logic                           stall,
    output logic [DEC_WIDTH-1:0]           out_valid,
    output logic [DEC_WIDTH*ENTRY_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]         count
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]                    perf_full,
    output logic [31:0]                    perf_empty
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(FETCH_WIDTH) + 1;

    logic [ENTRY_W-1:0]           mem [DEPTH];
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [FETCH_WIDTH*OFF_W-1:0] slot_off;
    logic [OFF_W-1:0]             bundle_n;
    logic                         enq_fire;
    logic                         deq_fire;
    logic [CNT_W-1:0]             enq_n;
    logic [CNT_W-1:0]             deq_n;

    ibuf_compact #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .OFF_W       (OFF_W)
    ) u_compact (
        .mask   (in_mask),
        .offset (slot_off),
        .enq_n  (bundle_n)
    );

    // Ready looks only at registered count so it never depends on this
    // cycle's dequeue decision (keeps the IFU timing path short).
    assign in_ready = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign enq_fire = in_valid & in_ready & ~flush;
    assign deq_fire = ~stall & ~flush;
    assign enq_n    = enq_fire ? CNT_W'(bundle_n) : '0;
    assign deq_n    = ~deq_fire ? '0 :
                      (count > CNT_W'(DEC_WIDTH)) ? CNT_W'(DEC_WIDTH) : count;

    // Read lanes straight from storage; pointer add wraps because DEPTH is
    // a power of two.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            out_valid[i]                 = (count > CNT_W'(i)) & ~flush;
            out_data[i*ENTRY_W +: ENTRY_W] = mem[head + PTR_W'(i)];
        end
    end

    // Entry storage is deliberately not reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (in_mask[i]) begin
                    mem[tail + PTR_W'(slot_off[i*OFF_W +: OFF_W])] <= in_data[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

`ifdef IBUF_PERF_EN
    // Saturating counters; only rst clears them, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full  <= '0;
            perf_empty <= '0;
        end else begin
            if (in_valid && !in_ready && perf_full != '1) begin
                perf_full <= perf_full + 32'd1;
            end
            if (count == '0 && !stall && perf_empty != '1) begin
                perf_empty <= perf_empty + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

    assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
    assert property (@(posedge clk) disable iff (rst) enq_fire |-> in_ready);

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed self-checking bench for inst_buffer with
// hand-computed expected occupancy, lane masks and lane contents.
module tb_inst_buffer;
    import ibuf_pkg::*;

    localparam int EW = $bits(IbufEntry);

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_mask;
    logic [4*EW-1:0] in_data;
    logic          stall;
    logic [3:0]    out_valid;
    logic [4*EW-1:0] out_data;
    logic [4:0]    count;

    int num_checks;
    int num_errors;

    inst_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_data   (in_data),
        .stall     (stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input int id);
        IbufEntry e;
        e.inst       = 32'hC0DE_0000 | 32'(id);
        e.pc         = 39'(id * 4);
        e.fsq_offset = 9'(id);
        return e;
    endfunction

    function automatic logic [EW-1:0] lane(input int i);
        return out_data[i*EW +: EW];
    endfunction

    task automatic checkOutput(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot i carries entry mk(base+i); inputs settle 1 time unit before checks.
    task automatic applyStimulus(input logic v, input logic [3:0] m, input int base,
                                 input logic st, input logic fl);
        in_valid = v;
        in_mask  = m;
        stall    = st;
        flush    = fl;
        for (int i = 0; i < 4; i++) begin
            in_data[i*EW +: EW] = mk(base + i);
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_count", count, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        // Full bundle, no stall: visible next cycle, drained the one after.
        applyStimulus(1'b1, 4'b1111, 1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        checkOutput("t1_count", count, 4);
        checkOutput("t1_out_valid", out_valid, 4'b1111);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_lane%0d", i), lane(i), mk(1 + i));
        tick();
        checkOutput("t1_drained_count", count, 0);
        checkOutput("t1_drained_valid", out_valid, 0);

        // Sparse mask: only slots 1 and 3 (ids 6, 8) stored.
        applyStimulus(1'b1, 4'b1010, 5, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        checkOutput("t2_count", count, 2);
        checkOutput("t2_out_valid", out_valid, 4'b0011);
        checkOutput("t2_lane0", lane(0), mk(6));
        checkOutput("t2_lane1", lane(1), mk(8));
        applyStimulus(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        tick();
        checkOutput("t2_drained_count", count, 0);

        // Fill under stall up to the ready boundary.
        applyStimulus(1'b1, 4'b1111, 10, 1'b1, 1'b0);
        tick();
        checkOutput("t3_count4", count, 4);
        applyStimulus(1'b1, 4'b1111, 14, 1'b1, 1'b0);
        tick();
        checkOutput("t3_count8", count, 8);
        applyStimulus(1'b1, 4'b1111, 18, 1'b1, 1'b0);
        tick();
        checkOutput("t3_count12", count, 12);
        checkOutput("t3_ready_at12", in_ready, 1);
        applyStimulus(1'b1, 4'b0001, 22, 1'b1, 1'b0);
        tick();
        checkOutput("t3_count13", count, 13);
        checkOutput("t3_ready_at13", in_ready, 0);
        applyStimulus(1'b1, 4'b1111, 30, 1'b1, 1'b0);
        tick();
        checkOutput("t3_blocked_count", count, 13);
        applyStimulus(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        checkOutput("t3_out_valid", out_valid, 4'b1111);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t3_lane%0d", i), lane(i), mk(10 + i));
        tick();
        checkOutput("t3_count9", count, 9);
        checkOutput("t3_ready_at9", in_ready, 1);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t3_second_lane%0d", i), lane(i), mk(14 + i));

        // Flush at count 9 with a bundle present: everything discarded.
        applyStimulus(1'b1, 4'b1111, 60, 1'b0, 1'b1);
        checkOutput("t5_valid_during_flush", out_valid, 0);
        tick();
        applyStimulus(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        checkOutput("t5_count", count, 0);
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_in_ready", in_ready, 1);

        // Move head to 14: enqueue 14 entries, then drain them all.
        applyStimulus(1'b1, 4'b1111, 100, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b1111, 104, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b1111, 108, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b0011, 112, 1'b1, 1'b0);
        tick();
        checkOutput("t4_fill_count", count, 14);
        applyStimulus(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("t4_last_count", count, 2);
        checkOutput("t4_last_lane0", lane(0), mk(112));
        tick();
        checkOutput("t4_empty_count", count, 0);

        // Tail wrap: entries at 14,15 then 0..3.
        applyStimulus(1'b1, 4'b0011, 50, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b1111, 52, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        checkOutput("t4_wrap_count", count, 6);
        checkOutput("t4_wrap_valid", out_valid, 4'b1111);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t4_wrap_lane%0d", i), lane(i), mk(50 + i));

        // Simultaneous enqueue of 4 and dequeue of 3.
        applyStimulus(1'b0, 4'b0000, 0, 1'b0, 1'b0);
        tick();
        checkOutput("t6_count2", count, 2);
        applyStimulus(1'b1, 4'b0001, 56, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b1111, 57, 1'b0, 1'b0);
        checkOutput("t6_count3", count, 3);
        checkOutput("t6_valid3", out_valid, 4'b0111);
        checkOutput("t6_lane0", lane(0), mk(54));
        checkOutput("t6_lane2", lane(2), mk(56));
        tick();
        applyStimulus(1'b0, 4'b0000, 0, 1'b1, 1'b0);
        checkOutput("t6_count_next", count, 4);
        checkOutput("t6_valid_next", out_valid, 4'b1111);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t6_lane%0d_next", i), lane(i), mk(57 + i));

        // Empty mask with in_valid is a no-op.
        applyStimulus(1'b1, 4'b0000, 70, 1'b1, 1'b0);
        tick();
        checkOutput("zero_mask_count", count, 4);
        checkOutput("zero_mask_lane0", lane(0), mk(57));

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
